// File: rtl/pifo_task_issuer.sv
// Request-side front end for the PIFO task generator: buffers pushes, arbitrates
// push/pop into the generator port and returns pop results after a fixed latency.
module pifo_task_issuer #(
    parameter  int PTW      = 16,
    parameter  int MTW      = 0,
    parameter  int TREE_NUM = 4,
    parameter  int CTW      = 10,
    parameter  int IN_DEPTH = 4,
    parameter  int POP_LAT  = 2,
    localparam int DW       = MTW + PTW,
    localparam int TNB      = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_s_valid,
    output logic           o_s_ready,
    input  logic [TNB-1:0] i_s_tree_id,
    input  logic [DW-1:0]  i_s_data,
    input  logic           i_pop_req,
    output logic           o_pop_ack,
    output logic           o_push,
    output logic [TNB-1:0] o_push_tree_id,
    output logic [DW-1:0]  o_push_data,
    output logic           o_pop,
    input  logic           i_task_fifo_full,
    input  logic [TNB-1:0] i_pop_tree_id,
    input  logic [DW-1:0]  i_pop_data,
    output logic           o_r_valid,
    output logic [TNB-1:0] o_r_tree_id,
    output logic [DW-1:0]  o_r_data,
    output logic [CTW-1:0] o_occupancy
);
    localparam int PW = $clog2(IN_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(IN_DEPTH);

    typedef struct packed {
        logic [TNB-1:0] tree_id;
        logic [DW-1:0]  data;
    } entry_t;

    typedef enum logic {LAST_POP, LAST_PUSH} last_e;

    entry_t            mem [IN_DEPTH];
    entry_t            head;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    last_e             last;
    logic [POP_LAT-1:0] vld_pipe;

    logic wr_en, push_el, pop_el, grant_push, grant_pop;

    assign head      = mem[rd_ptr];
    assign o_s_ready = (count < FULL_CNT);
    assign wr_en     = i_s_valid && o_s_ready;

    assign push_el = (count != '0) && !i_task_fifo_full && (o_occupancy != {CTW{1'b1}});
    assign pop_el  = i_pop_req && (o_occupancy != '0);

    // On a tie the side not granted last time wins; last resets to POP so push wins first.
    assign grant_push = push_el && (!pop_el || (last == LAST_POP));
    assign grant_pop  = pop_el && (!push_el || (last == LAST_PUSH));
    assign o_pop_ack  = grant_pop;

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= '{tree_id: i_s_tree_id, data: i_s_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            last           <= LAST_POP;
            o_push         <= 1'b0;
            o_push_tree_id <= '0;
            o_push_data    <= '1;
            o_pop          <= 1'b0;
            o_occupancy    <= '0;
            vld_pipe       <= '0;
            o_r_valid      <= 1'b0;
            o_r_tree_id    <= '0;
            o_r_data       <= '1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (grant_push) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, grant_push})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase

            if (grant_push) last <= LAST_PUSH;
            else if (grant_pop) last <= LAST_POP;

            o_push         <= grant_push;
            o_push_tree_id <= grant_push ? head.tree_id : '0;
            o_push_data    <= grant_push ? head.data : '1;
            o_pop          <= grant_pop;

            if (grant_push) o_occupancy <= o_occupancy + CTW'(1);
            else if (grant_pop) o_occupancy <= o_occupancy - CTW'(1);

            // One bit per in-flight pop; the exiting bit marks the cycle the result is valid.
            vld_pipe[0] <= o_pop;
            for (int i = 1; i < POP_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];

            o_r_valid <= vld_pipe[POP_LAT-1];
            if (vld_pipe[POP_LAT-1]) begin
                o_r_tree_id <= i_pop_tree_id;
                o_r_data    <= i_pop_data;
            end
        end
    end
endmodule
